// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the DDR write/read round-robin arbiters.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    localparam int unsigned WD_CNT_W  = 17;
    localparam int unsigned MAX_CH    = 32;
    localparam int unsigned MAX_IDX_W = 5;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set request at or above ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_CH-1:0]    req,
        input logic [MAX_IDX_W-1:0] ptr,
        input int unsigned          n
    );
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            if (k < n && !r.valid) begin
                j = 32'(ptr) + k;
                if (j >= n) j = j - n;
                if (req[j[MAX_IDX_W-1:0]]) begin
                    r.valid = 1'b1;
                    r.idx   = j[MAX_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_wr_arbiter_rr_pick_logic.sv
// Round-robin picker: rotate by pointer, priority-encode, un-rotate.
module rr_pick_logic #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IW     = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IW-1:0]     i_ptr,
    output logic [IW-1:0]     o_idx,
    output logic              o_valid
);

    logic [NUM_CH-1:0] w_rot;
    logic [IW-1:0]     w_off;
    int                w_j;

    always_comb begin
        w_rot   = '0;
        w_off   = '0;
        o_valid = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= int'(NUM_CH)) w_j = w_j - int'(NUM_CH);
            w_rot[k] = i_req[IW'(w_j)];
        end
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (!o_valid && w_rot[k]) begin
                o_valid = 1'b1;
                w_off   = IW'(k);
            end
        end
        w_j = int'(i_ptr) + int'(w_off);
        if (w_j >= int'(NUM_CH)) w_j = w_j - int'(NUM_CH);
        o_idx = IW'(w_j);
    end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Round-robin arbiter sharing one DDR write port among NUM_CH write cells.
// Optional burst watchdog: define WR_ARB_WATCHDOG_EN.
module ddr_wr_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned ADDR_WIDTH  = 27,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned DQ_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                           ddr_clk,
    input  logic                           ddr_rstn,
    input  logic [NUM_CH-1:0]              ch_wreq,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_waddr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]    ch_wr_len,
    input  logic [NUM_CH*8*DQ_WIDTH-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]              ch_wdata_req,
    output logic [NUM_CH-1:0]              ch_wdone,
    output logic                           ddr_wreq,
    output logic [ADDR_WIDTH-1:0]          ddr_waddr,
    output logic [LEN_WIDTH-1:0]           ddr_wr_len,
    output logic [8*DQ_WIDTH-1:0]          ddr_wdata,
    input  logic                           ddr_wdata_req,
    input  logic                           ddr_wdone,
    output logic [NUM_CH-1:0]              arb_grant,
    output logic                           arb_busy,
    output logic                           arb_err
);

    localparam int unsigned IW = ch_idx_w(NUM_CH);
    localparam int unsigned DW = 8 * DQ_WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

    arb_state_t        r_state;
    logic [IW-1:0]     r_g;
    logic [IW-1:0]     r_rr_ptr;
    logic [NUM_CH-1:0] r_grant;

    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_valid;
    logic              w_gnt_any;
    logic              w_req_g;
    logic              w_in_burst;
    logic              w_wd_hit;

    rr_pick_logic #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_pick (
        .i_req   (ch_wreq),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_gnt_any  = |r_grant;
    assign w_req_g    = ch_wreq[r_g];
    assign w_in_burst = (r_state == ST_REQ) || (r_state == ST_DATA);

`ifdef WR_ARB_WATCHDOG_EN
    localparam logic [WD_CNT_W-1:0] WD_LAST = WD_CNT_W'(TIMEOUT_CYC - 1);

    logic [WD_CNT_W-1:0] r_wd_cnt;
    logic                r_err;

    assign w_wd_hit = w_in_burst && w_gnt_any && (r_wd_cnt == WD_LAST);
    assign arb_err  = r_err;

    // REQ is only entered from IDLE, so clearing in IDLE restarts each burst.
    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_wd_cnt <= '0;
            end else if (w_in_burst) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_wd_hit) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_wd_hit = 1'b0;
    assign arb_err  = 1'b0;
`endif

    assign ddr_wreq = (r_state == ST_REQ) && w_gnt_any && w_req_g;

    assign ch_wdata_req = (w_in_burst && ddr_wdata_req) ? r_grant : '0;
    assign ch_wdone     = (((r_state == ST_DATA) && ddr_wdone) || w_wd_hit)
                          ? r_grant : '0;

    assign ddr_waddr  = w_gnt_any ? ch_waddr[r_g*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign ddr_wr_len = w_gnt_any ? ch_wr_len[r_g*LEN_WIDTH +: LEN_WIDTH] : '0;
    assign ddr_wdata  = w_gnt_any ? ch_wdata[r_g*DW +: DW] : '0;

    assign arb_grant = r_grant;
    assign arb_busy  = (r_state != ST_IDLE);

    always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
        if (!ddr_rstn) begin
            r_state  <= ST_IDLE;
            r_g      <= '0;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_g     <= w_pick_idx;
                        r_grant <= NUM_CH'(1) << w_pick_idx;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_wd_hit) begin
                        r_state <= ST_DONE;
                    end else if (ddr_wdata_req) begin
                        r_state <= ST_DATA;
                    end else if (!w_req_g) begin
                        // Cell withdrew: drop grant, keep pointer.
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (w_wd_hit || ddr_wdone) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_rr_ptr <= (r_g == LAST_IDX) ? '0 : r_g + 1'b1;
                    r_grant  <= '0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Directed bench for ddr_wr_arbiter; define WR_ARB_WATCHDOG_EN to add the watchdog case.
module tb_ddr_wr_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 27;
    localparam int LW  = 16;
    localparam int DQ  = 32;
    localparam int DW  = 8 * DQ;
`ifdef WR_ARB_WATCHDOG_EN
    localparam int TO = 100;
`else
    localparam int TO = 65535;
`endif

    logic                ddr_clk = 1'b0;
    logic                ddr_rstn;
    logic [NCH-1:0]      ch_wreq;
    logic [NCH*AW-1:0]   ch_waddr;
    logic [NCH*LW-1:0]   ch_wr_len;
    logic [NCH*DW-1:0]   ch_wdata;
    logic [NCH-1:0]      ch_wdata_req;
    logic [NCH-1:0]      ch_wdone;
    logic                ddr_wreq;
    logic [AW-1:0]       ddr_waddr;
    logic [LW-1:0]       ddr_wr_len;
    logic [DW-1:0]       ddr_wdata;
    logic                ddr_wdata_req;
    logic                ddr_wdone;
    logic [NCH-1:0]      arb_grant;
    logic                arb_busy;
    logic                arb_err;

    int n_cmp = 0;
    int n_err = 0;

    ddr_wr_arbiter #(
        .NUM_CH      (NCH),
        .ADDR_WIDTH  (AW),
        .LEN_WIDTH   (LW),
        .DQ_WIDTH    (DQ),
        .TIMEOUT_CYC (TO)
    ) dut (
        .ddr_clk       (ddr_clk),
        .ddr_rstn      (ddr_rstn),
        .ch_wreq       (ch_wreq),
        .ch_waddr      (ch_waddr),
        .ch_wr_len     (ch_wr_len),
        .ch_wdata      (ch_wdata),
        .ch_wdata_req  (ch_wdata_req),
        .ch_wdone      (ch_wdone),
        .ddr_wreq      (ddr_wreq),
        .ddr_waddr     (ddr_waddr),
        .ddr_wr_len    (ddr_wr_len),
        .ddr_wdata     (ddr_wdata),
        .ddr_wdata_req (ddr_wdata_req),
        .ddr_wdone     (ddr_wdone),
        .arb_grant     (arb_grant),
        .arb_busy      (arb_busy),
        .arb_err       (arb_err)
    );

    always #5 ddr_clk = ~ddr_clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ddr_clk);
        #1;
    endtask

    // Entered in REQ with channel ch granted; leaves in the IDLE after DONE.
    task automatic run_burst(input int ch, input int beats, input bit drop);
        int         pulses;
        int         stray;
        logic [3:0] oh;
        oh     = 4'(1 << ch);
        pulses = 0;
        stray  = 0;
        chk("burst_grant", 256'(arb_grant), 256'(oh));
        chk("burst_wreq", 256'(ddr_wreq), 256'(1'b1));
        for (int b = 0; b < beats; b++) begin
            ddr_wdata_req = 1'b1;
            #1;
            if (ch_wdata_req == oh) pulses++;
            if ((ch_wdata_req & ~oh) != 4'b0) stray++;
            tick();
            if (drop) ch_wreq[ch] = 1'b0;
        end
        ddr_wdata_req = 1'b0;
        ddr_wdone     = 1'b1;
        #1;
        chk("burst_wdone", 256'(ch_wdone), 256'(oh));
        chk("data_wreq", 256'(ddr_wreq), 256'(1'b0));
        tick();
        ddr_wdone = 1'b0;
        #1;
        chk("done_busy", 256'(arb_busy), 256'(1'b1));
        chk("done_wdone", 256'(ch_wdone), 256'(4'b0));
        chk("done_wreq", 256'(ddr_wreq), 256'(1'b0));
        tick();
        chk("bubble_grant", 256'(arb_grant), 256'(4'b0));
        chk("bubble_busy", 256'(arb_busy), 256'(1'b0));
        chk("beat_count", 256'(pulses), 256'(beats));
        chk("stray_count", 256'(stray), 256'(0));
    endtask

    initial begin
        int         bad;
        logic       wd;
`ifdef WR_ARB_WATCHDOG_EN
        int         c;
        bit         hit;
`endif
        ddr_rstn      = 1'b0;
        ch_wreq       = '0;
        ddr_wdata_req = 1'b0;
        ddr_wdone     = 1'b0;
        ch_waddr      = {27'h3000, 27'h2000, 27'h100, 27'h400};
        ch_wr_len     = {16'h40, 16'h30, 16'h28, 16'h10};
        for (int i = 0; i < NCH; i++) begin
            ch_wdata[i*DW +: DW] = {8{32'hA5A50000 + 32'(i)}};
        end
        #3;
        chk("rst_grant", 256'(arb_grant), 256'(4'b0));
        chk("rst_busy", 256'(arb_busy), 256'(1'b0));
        chk("rst_err", 256'(arb_err), 256'(1'b0));
        chk("rst_wreq", 256'(ddr_wreq), 256'(1'b0));
        chk("rst_waddr", 256'(ddr_waddr), 256'(0));
        chk("rst_wdata", 256'(ddr_wdata), 256'(0));
        tick();
        tick();
        ddr_rstn = 1'b1;

        // Single channel, 40 beats
        ch_wreq = 4'b0010;
        #1;
        chk("t1_pre_grant", 256'(arb_grant), 256'(4'b0));
        chk("t1_pre_wreq", 256'(ddr_wreq), 256'(1'b0));
        tick();
        chk("t1_addr", 256'(ddr_waddr), 256'(27'h100));
        chk("t1_len", 256'(ddr_wr_len), 256'(16'h28));
        chk("t1_data", 256'(ddr_wdata), {8{32'hA5A50001}});
        run_burst(1, 40, 1'b1);

        // Abort in REQ, pointer must remain at 2
        ch_wreq = 4'b0100;
        tick();
        chk("ab_grant", 256'(arb_grant), 256'(4'b0100));
        ch_wreq = 4'b0000;
        #1;
        chk("ab_wreq", 256'(ddr_wreq), 256'(1'b0));
        chk("ab_wdone_req", 256'(ch_wdone), 256'(4'b0));
        tick();
        chk("ab_idle_grant", 256'(arb_grant), 256'(4'b0));
        chk("ab_idle_busy", 256'(arb_busy), 256'(1'b0));
        chk("ab_wdone", 256'(ch_wdone), 256'(4'b0));
        ch_wreq = 4'b1100;
        tick();
        run_burst(2, 1, 1'b1);
        ch_wreq = 4'b0000;

        // Stray controller pulses while idle
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            ddr_wdata_req = 1'($urandom_range(0, 1));
            ddr_wdone     = 1'($urandom_range(0, 1));
            #1;
            if (ch_wdata_req != 4'b0 || ch_wdone != 4'b0) bad++;
            if (arb_busy) bad++;
            tick();
        end
        chk("iso_idle", 256'(bad), 256'(0));

        // Random strobes while channel 0 holds the grant
        ddr_wdata_req = 1'b0;
        ddr_wdone     = 1'b0;
        ch_wreq       = 4'b0001;
        tick();
        chk("iso_grant", 256'(arb_grant), 256'(4'b0001));
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            wd            = 1'($urandom_range(0, 1));
            ddr_wdata_req = wd;
            #1;
            if (ch_wdata_req != {3'b000, wd}) bad++;
            if (ch_wdone != 4'b0) bad++;
            tick();
        end
        chk("iso_gnt", 256'(bad), 256'(0));
        ddr_wdata_req = 1'b1;
        tick();
        ddr_wdone = 1'b1;
        #1;
        chk("both_wdreq", 256'(ch_wdata_req), 256'(4'b0001));
        chk("both_wdone", 256'(ch_wdone), 256'(4'b0001));
        ch_wreq = 4'b0000;
        tick();
        #1;
        chk("done_stray_req", 256'(ch_wdata_req), 256'(4'b0));
        chk("done_stray_done", 256'(ch_wdone), 256'(4'b0));
        tick();
        ddr_wdata_req = 1'b0;
        ddr_wdone     = 1'b0;

        // Reset in the middle of DATA
        ch_wreq = 4'b0100;
        tick();
        ddr_wdata_req = 1'b1;
        tick();
        chk("mid_fwd", 256'(ch_wdata_req), 256'(4'b0100));
        chk("mid_wreq", 256'(ddr_wreq), 256'(1'b0));
        ddr_rstn = 1'b0;
        #1;
        chk("arst_grant", 256'(arb_grant), 256'(4'b0));
        chk("arst_busy", 256'(arb_busy), 256'(1'b0));
        chk("arst_wdreq", 256'(ch_wdata_req), 256'(4'b0));
        chk("arst_waddr", 256'(ddr_waddr), 256'(0));
        chk("arst_wdata", 256'(ddr_wdata), 256'(0));
        ddr_wdata_req = 1'b0;
        ch_wreq       = 4'b0000;
        tick();
        ddr_rstn = 1'b1;

        // All channels requesting: order 0,1,2,3,0
        ch_wreq = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            run_burst(i % 4, 2, 1'b0);
            if (i == 4) ch_wreq = 4'b0000;
            tick();
        end
        chk("rr_end_idle", 256'(arb_busy), 256'(1'b0));

`ifdef WR_ARB_WATCHDOG_EN
        ch_wreq = 4'b0110;
        tick();
        chk("wd_grant", 256'(arb_grant), 256'(4'b0010));
        c   = 0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (i == 0) begin
                ddr_wdata_req = 1'b1;
            end else begin
                ddr_wdata_req = 1'b0;
                ch_wreq[1]    = 1'b0;
            end
            #1;
            c++;
            if (ch_wdone == 4'b0010) hit = 1'b1;
            else tick();
        end
        chk("wd_cycles", 256'(c), 256'(100));
        chk("wd_err_pre", 256'(arb_err), 256'(1'b0));
        tick();
        chk("wd_pulse_end", 256'(ch_wdone), 256'(4'b0));
        chk("wd_err", 256'(arb_err), 256'(1'b1));
        tick();
        tick();
        chk("wd_next", 256'(arb_grant), 256'(4'b0100));
        chk("wd_sticky", 256'(arb_err), 256'(1'b1));
`else
        chk("err_tied", 256'(arb_err), 256'(1'b0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
